// File: rtl/ltl_stream_pkg.sv
// Shared types for the LTL monitor symbol streamer.
// Symbol width, symbol type and streamer FSM states.
package ltl_stream_pkg;

    localparam int SYM_W = 8;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN
    } stream_state_e;

endpackage

// File: rtl/ltl_sym_fifo.sv
// Synchronous symbol FIFO with flush; full/empty derive from a registered count.
// Push and pop may coincide at any occupancy, including full.
module ltl_sym_fifo
    import ltl_stream_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  sym_t din,
    input  logic pop,
    output sym_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    sym_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/ltl_symbol_streamer.sv
// Packs trace proposition vectors into symbols and streams them to LTL monitors.
// Optional stutter removal when LTL_STREAM_DEDUP_EN is defined.
module ltl_symbol_streamer
    import ltl_stream_pkg::*;
#(
    parameter int NUM_PROPS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ARM_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trace_start,
    input  logic                 trace_end,
    input  logic                 prop_valid,
    input  logic [NUM_PROPS-1:0] prop_bits,
    output logic                 prop_ready,
    input  logic                 mon_hold,
    output logic                 mon_reset,
    output logic                 mon_run,
    output logic [SYM_W-1:0]     mon_symbols,
    output logic                 overflow,
    output logic [15:0]          sym_count,
    output logic                 busy
);

    localparam int ACW = $clog2(ARM_CYCLES + 1);
    localparam logic [ACW-1:0] ARM_LAST = ACW'(ARM_CYCLES - 1);
    localparam logic [ACW-1:0] ARM_MAX  = ACW'(ARM_CYCLES);

    stream_state_e  state_q;
    stream_state_e  state_d;
    logic [ACW-1:0] arm_q;
    logic           arm_done;

    sym_t           sym_in;
    sym_t           fifo_head;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_flush;
    logic           fifo_full;
    logic           fifo_empty;

    logic           can_pop;
    logic           restart;
    logic           run_d;
    logic           rst_d;
    logic           ovf_set;
    logic           dup;

    assign sym_in     = sym_t'(prop_bits);
    assign arm_done   = (arm_q >= ARM_LAST);
    assign can_pop    = !fifo_empty && !mon_hold;
    assign busy       = (state_q != IDLE);
    assign prop_ready = !fifo_full
                     && (state_q == ARM || state_q == STREAM);
    assign ovf_set    = prop_valid && !prop_ready
                     && (state_q == ARM || state_q == STREAM);
    // A flushing cycle never pushes, so the dedup tracker stays in step.
    assign fifo_push  = prop_valid && prop_ready && !dup && !fifo_flush;

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        run_d      = 1'b0;
        rst_d      = mon_reset;
        restart    = 1'b0;
        if (trace_start) begin
            state_d    = ARM;
            fifo_flush = 1'b1;
            rst_d      = 1'b1;
            restart    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    rst_d = 1'b1;
                end
                ARM: begin
                    if (trace_end) begin
                        fifo_flush = 1'b1;
                        state_d    = IDLE;
                    end else if (arm_done && can_pop) begin
                        // Release reset together with the first symbol.
                        fifo_pop = 1'b1;
                        run_d    = 1'b1;
                        rst_d    = 1'b0;
                        state_d  = STREAM;
                    end
                end
                STREAM: begin
                    fifo_pop = can_pop;
                    run_d    = can_pop;
                    if (trace_end) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                        rst_d   = 1'b1;
                    end else begin
                        fifo_pop = can_pop;
                        run_d    = can_pop;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rst_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            arm_q       <= '0;
            overflow    <= 1'b0;
            sym_count   <= '0;
            mon_reset   <= 1'b1;
            mon_run     <= 1'b0;
            mon_symbols <= '0;
        end else begin
            state_q   <= state_d;
            mon_reset <= rst_d;
            mon_run   <= run_d;
            if (fifo_pop) begin
                mon_symbols <= fifo_head;
            end
            if (restart) begin
                arm_q     <= '0;
                overflow  <= 1'b0;
                sym_count <= '0;
            end else begin
                if (state_q == ARM && arm_q != ARM_MAX) begin
                    arm_q <= arm_q + ACW'(1);
                end
                if (ovf_set) begin
                    overflow <= 1'b1;
                end
                if (fifo_pop && sym_count != 16'hFFFF) begin
                    sym_count <= sym_count + 16'd1;
                end
            end
        end
    end

`ifdef LTL_STREAM_DEDUP_EN
    sym_t last_q;
    logic last_vld_q;

    assign dup = last_vld_q && (sym_in == last_q);

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            last_vld_q <= 1'b0;
        end else if (fifo_push) begin
            last_vld_q <= 1'b1;
            last_q     <= sym_in;
        end
    end
`else
    assign dup = 1'b0;
`endif

    ltl_sym_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (sym_in),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
